// File: rtl/seq_shifter_if.sv
// Handshake bundle between the execute-stage controller and the multi-cycle shifter.
// The controller drives the request side; the shifter drives busy/done/result.
interface seq_shifter_if #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
);
  logic             start;
  logic             flush;
  logic [1:0]       mode;
  logic [WIDTH-1:0] operand;
  logic [SHW-1:0]   shamt;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (
    output start, flush, mode, operand, shamt,
    input  busy, done, result
  );

  modport slave (
    input  start, flush, mode, operand, shamt,
    output busy, done, result
  );
endinterface

// File: rtl/seq_shifter.sv
// Multi-cycle shifter (SLL/SRL/SRA/ROL) that advances at most MAX_STEP bit positions per
// cycle, plus a protocol checker instantiated alongside it.
module seq_shifter_chk #(
  parameter int WIDTH = 32
) (
  input logic             clk,
  input logic             rst_n,
  input logic             busy,
  input logic             done,
  input logic [WIDTH-1:0] result
);
  // done is a lone pulse outside busy, and result only moves on that pulse
  a_done_not_busy: assert property (@(posedge clk) disable iff (!rst_n) done |-> !busy);
  a_done_pulse:    assert property (@(posedge clk) disable iff (!rst_n) done |=> !done);
  a_result_hold:   assert property (@(posedge clk) disable iff (!rst_n) !$stable(result) |-> done);
endmodule

module seq_shifter #(
  parameter int WIDTH    = 32,
  parameter int MAX_STEP = 4
) (
  input logic          clk,
  input logic          rst_n,
  seq_shifter_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW:0] MAX_STEP_W = MAX_STEP[SHW:0];

  localparam logic [1:0] MODE_SLL = 2'b00;
  localparam logic [1:0] MODE_SRL = 2'b01;
  localparam logic [1:0] MODE_ROL = 2'b10;
  localparam logic [1:0] MODE_SRA = 2'b11;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic             accept_s;
  logic             advance_s;
  logic             finish_s;
  logic             abort_s;

  logic [WIDTH-1:0] work_r;
  logic [SHW-1:0]   rem_r;
  logic [1:0]       mode_r;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] result_r;

  logic [SHW:0]     rem_ext_s;
  logic [SHW:0]     step_s;
  logic             last_s;
  logic [SHW-1:0]   rem_next_s;
  logic [WIDTH-1:0] shifted_s;

  // Mux of MAX_STEP+1 fixed shifts keeps the per-cycle shifter small.
  function automatic logic [WIDTH-1:0] shift_by(
    input logic [WIDTH-1:0] val,
    input logic [SHW:0]     amt,
    input logic [1:0]       md
  );
    logic [WIDTH-1:0] res;
    res = val;
    for (int k = 1; k <= MAX_STEP; k++) begin
      if (int'(amt) == k) begin
        case (md)
          MODE_SLL: res = val << k;
          MODE_SRL: res = val >> k;
          MODE_SRA: res = $signed(val) >>> k;
          MODE_ROL: res = (val << k) | (val >> (WIDTH - k));
          default:  res = val;
        endcase
      end
    end
    return res;
  endfunction

  // Step size, remaining-count update and shifted value for the current busy cycle
  always_comb begin
    rem_ext_s  = {1'b0, rem_r};
    last_s     = (rem_ext_s <= MAX_STEP_W);
    step_s     = MAX_STEP_W;
    if (last_s) begin
      step_s = rem_ext_s;
    end else begin
      step_s = MAX_STEP_W;
    end
    rem_next_s = rem_r - step_s[SHW-1:0];
    shifted_s  = shift_by(work_r, step_s, mode_r);
  end

  // Next-state and control decode; flush outranks completion, start wins when idle
  always_comb begin
    state_s   = state_r;
    accept_s  = 1'b0;
    advance_s = 1'b0;
    finish_s  = 1'b0;
    abort_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          state_s  = ST_RUN;
          accept_s = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (bus.flush) begin
          state_s = ST_IDLE;
          abort_s = 1'b1;
        end else if (last_s) begin
          state_s  = ST_IDLE;
          finish_s = 1'b1;
        end else begin
          state_s   = ST_RUN;
          advance_s = 1'b1;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work_r   <= {WIDTH{1'b0}};
      rem_r    <= {SHW{1'b0}};
      mode_r   <= 2'b00;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      result_r <= {WIDTH{1'b0}};
    end else begin
      busy_r <= (state_s == ST_RUN);
      done_r <= finish_s;
      if (accept_s) begin
        work_r <= bus.operand;
        rem_r  <= bus.shamt;
        mode_r <= bus.mode;
      end else if (abort_s) begin
        rem_r <= {SHW{1'b0}};
      end else if (advance_s || finish_s) begin
        work_r <= shifted_s;
        rem_r  <= rem_next_s;
      end else begin
        work_r <= work_r;
      end
      if (finish_s) begin
        result_r <= shifted_s;
      end else begin
        result_r <= result_r;
      end
    end
  end

  assign bus.busy   = busy_r;
  assign bus.done   = done_r;
  assign bus.result = result_r;

  seq_shifter_chk #(.WIDTH(WIDTH)) u_chk (
    .clk    (clk),
    .rst_n  (rst_n),
    .busy   (busy_r),
    .done   (done_r),
    .result (result_r)
  );
endmodule
